// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the two-client memory port arbiter: FSM states, op codes, client ids.
package mem_port_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      BUSY    = 2'd1,
      RELEASE = 2'd2
   } state_t;

   typedef enum logic {
      OP_RD = 1'b0,
      OP_WR = 1'b1
   } op_t;

   localparam logic CLIENT0 = 1'b0;
   localparam logic CLIENT1 = 1'b1;

   // A request carrying both rd and wr is serviced as a write.
   function automatic op_t req_op(input logic rd, input logic wr);
      return wr ? OP_WR : OP_RD;
   endfunction

endpackage

// File: rtl/mem_port_arbiter_rr.sv
// Two-way round-robin arbiter: on contention the client other than last_grant wins.
module rr_arbiter2
   import mem_port_arbiter_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last_grant,
   output logic [1:0] grant
);

   always_comb begin
      grant = req;
      if (req == 2'b11) begin
         grant = (last_grant == CLIENT1) ? 2'b01 : 2'b10;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises two client ports onto one word memory; holds the memory handshake until
// mem_ready, then returns read data and a one-cycle ack to the granted client.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int ADR_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  c0_rd,
   input  logic                  c0_wr,
   input  logic [ADR_WIDTH-1:0]  c0_addr,
   input  logic [DATA_WIDTH-1:0] c0_wdata,
   output logic [DATA_WIDTH-1:0] c0_rdata,
   output logic                  c0_ack,
   input  logic                  c1_rd,
   input  logic                  c1_wr,
   input  logic [ADR_WIDTH-1:0]  c1_addr,
   input  logic [DATA_WIDTH-1:0] c1_wdata,
   output logic [DATA_WIDTH-1:0] c1_rdata,
   output logic                  c1_ack,
   output logic                  mem_rd,
   output logic                  mem_wr,
   output logic [ADR_WIDTH-1:0]  mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   input  logic                  mem_ready
);

   state_t                state, state_d;
   logic                  last_grant, last_grant_d;
   logic                  gnt_id, gnt_id_d;
   logic [1:0]            req, grant;
   logic                  sel;
   op_t                   op;
   logic                  mem_rd_d, mem_wr_d, c0_ack_d, c1_ack_d;
   logic [ADR_WIDTH-1:0]  mem_addr_d;
   logic [DATA_WIDTH-1:0] mem_wdata_d, c0_rdata_d, c1_rdata_d;

   assign req = {c1_rd | c1_wr, c0_rd | c0_wr};

   rr_arbiter2 u_arb (
      .req        (req),
      .last_grant (last_grant),
      .grant      (grant)
   );

   always_comb begin
      state_d      = state;
      last_grant_d = last_grant;
      gnt_id_d     = gnt_id;
      mem_rd_d     = mem_rd;
      mem_wr_d     = mem_wr;
      mem_addr_d   = mem_addr;
      mem_wdata_d  = mem_wdata;
      c0_rdata_d   = c0_rdata;
      c1_rdata_d   = c1_rdata;
      c0_ack_d     = 1'b0;
      c1_ack_d     = 1'b0;
      sel          = grant[1];
      op           = sel ? req_op(c1_rd, c1_wr) : req_op(c0_rd, c0_wr);

      case (state)
         IDLE: begin
            if (|grant) begin
               gnt_id_d     = sel;
               last_grant_d = sel;
               mem_addr_d   = sel ? c1_addr  : c0_addr;
               mem_wdata_d  = sel ? c1_wdata : c0_wdata;
               mem_wr_d     = (op == OP_WR);
               mem_rd_d     = (op == OP_RD);
               state_d      = BUSY;
            end
         end
         BUSY: begin
            if (mem_ready) begin
               if (mem_rd) begin
                  if (gnt_id == CLIENT0) c0_rdata_d = mem_rdata;
                  else                   c1_rdata_d = mem_rdata;
               end
               if (gnt_id == CLIENT0) c0_ack_d = 1'b1;
               else                   c1_ack_d = 1'b1;
               mem_rd_d = 1'b0;
               mem_wr_d = 1'b0;
               state_d  = RELEASE;
            end
         end
         RELEASE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         last_grant <= CLIENT1;
         gnt_id     <= CLIENT0;
         mem_rd     <= 1'b0;
         mem_wr     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         c0_rdata   <= '0;
         c1_rdata   <= '0;
         c0_ack     <= 1'b0;
         c1_ack     <= 1'b0;
      end else begin
         state      <= state_d;
         last_grant <= last_grant_d;
         gnt_id     <= gnt_id_d;
         mem_rd     <= mem_rd_d;
         mem_wr     <= mem_wr_d;
         mem_addr   <= mem_addr_d;
         mem_wdata  <= mem_wdata_d;
         c0_rdata   <= c0_rdata_d;
         c1_rdata   <= c1_rdata_d;
         c0_ack     <= c0_ack_d;
         c1_ack     <= c1_ack_d;
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: word memory model plus transaction-level reference.
module tb_mem_port_arbiter;

   localparam int DW = 16;
   localparam int AW = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          c0_rd, c0_wr, c1_rd, c1_wr;
   logic [AW-1:0] c0_addr, c1_addr;
   logic [DW-1:0] c0_wdata, c1_wdata, c0_rdata, c1_rdata;
   logic          c0_ack, c1_ack;
   logic          mem_rd, mem_wr, mem_ready;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata, mem_rdata;

   always #5 clk = ~clk;

   mem_port_arbiter #(.DATA_WIDTH(DW), .ADR_WIDTH(AW)) dut (
      .clk(clk), .rst(rst),
      .c0_rd(c0_rd), .c0_wr(c0_wr), .c0_addr(c0_addr), .c0_wdata(c0_wdata),
      .c0_rdata(c0_rdata), .c0_ack(c0_ack),
      .c1_rd(c1_rd), .c1_wr(c1_wr), .c1_addr(c1_addr), .c1_wdata(c1_wdata),
      .c1_rdata(c1_rdata), .c1_ack(c1_ack),
      .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ready(mem_ready)
   );

   // Word memory: ready pulses mdelay edges after a strobe is seen, then waits for release.
   logic [DW-1:0] mem [0:65535];
   int unsigned   mcnt, mdelay;
   bit            mwait, rand_delay;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_ready <= 1'b0;
         mem_rdata <= '0;
         mcnt  = 0;
         mwait = 1'b0;
      end else begin
         mem_ready <= 1'b0;
         mem_rdata <= DW'($urandom);
         if (mwait) begin
            if (!mem_rd && !mem_wr) mwait = 1'b0;
         end else if (mem_rd || mem_wr) begin
            if (mcnt == 0) mdelay = rand_delay ? $urandom_range(1, 6) : 5;
            mcnt++;
            if (mcnt >= mdelay) begin
               mem_ready <= 1'b1;
               mcnt  = 0;
               mwait = 1'b1;
               if (mem_wr) mem[mem_addr] = mem_wdata;
               else        mem_rdata <= mem[mem_addr];
            end
         end
      end
   end

   typedef struct {
      bit            cl;
      bit            wr;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
   } txn_t;

   txn_t          pend[$];
   int            grant_log[$];
   int            grant_cyc[$];
   logic [DW-1:0] ref_mem [0:65535];
   logic [DW-1:0] ref_rdata [2];
   bit            ref_last, prev_strobe, auto_drop;
   logic [AW-1:0] held_addr;
   logic [DW-1:0] held_wdata;
   int            cyc, last_ack_cyc;
   int            tests, fails;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic ref_reset();
      pend.delete();
      ref_last     = 1'b1;
      ref_rdata[0] = '0;
      ref_rdata[1] = '0;
      prev_strobe  = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_data"}, {c0_rdata, c1_rdata, mem_addr}, '0);
      check({tag, "_ctrl"}, {mem_wdata, c0_ack, c1_ack, mem_rd, mem_wr}, '0);
   endtask

   task automatic issue(input bit cl, input bit rd, input bit wr,
                        input logic [AW-1:0] a, input logic [DW-1:0] d);
      if (cl) begin c1_rd = rd; c1_wr = wr; c1_addr = a; c1_wdata = d; end
      else    begin c0_rd = rd; c0_wr = wr; c0_addr = a; c0_wdata = d; end
   endtask

   // One clock of observation: new grants are predicted from the held requests and the
   // round-robin rule; acks retire the oldest grant against the reference memory.
   task automatic step();
      txn_t       t;
      bit         s;
      logic [1:0] rq;
      @(negedge clk);
      cyc++;
      s  = mem_rd | mem_wr;
      rq = {c1_rd | c1_wr, c0_rd | c0_wr};
      check("rd_wr_exclusive", {63'd0, mem_rd & mem_wr}, 0);
      check("ack_exclusive", {63'd0, c0_ack & c1_ack}, 0);
      if (s && !prev_strobe) begin
         check("grant_has_request", {62'd0, rq != 2'b00}, 1);
         t.cl    = (rq == 2'b11) ? ~ref_last : rq[1];
         t.wr    = t.cl ? c1_wr : c0_wr;
         t.addr  = t.cl ? c1_addr : c0_addr;
         t.wdata = t.cl ? c1_wdata : c0_wdata;
         check("grant_mem_rd", {63'd0, mem_rd}, {63'd0, !t.wr});
         check("grant_mem_wr", {63'd0, mem_wr}, {63'd0, t.wr});
         check("grant_addr", mem_addr, t.addr);
         if (t.wr) check("grant_wdata", mem_wdata, t.wdata);
         pend.push_back(t);
         ref_last = t.cl;
         grant_log.push_back(int'(t.cl));
         grant_cyc.push_back(cyc);
         held_addr  = mem_addr;
         held_wdata = mem_wdata;
      end else if (s) begin
         check("hold_addr", mem_addr, held_addr);
         check("hold_wdata", mem_wdata, held_wdata);
      end
      if (c0_ack || c1_ack) begin
         if (pend.size() == 0) begin
            check("spurious_ack", {c1_ack, c0_ack}, 0);
         end else begin
            t = pend.pop_front();
            check("ack_client", {c1_ack, c0_ack}, t.cl ? 2'b10 : 2'b01);
            if (t.wr) ref_mem[t.addr] = t.wdata;
            else      ref_rdata[t.cl] = ref_mem[t.addr];
            last_ack_cyc = cyc;
            if (auto_drop) begin
               if (t.cl) begin c1_rd = 1'b0; c1_wr = 1'b0; end
               else      begin c0_rd = 1'b0; c0_wr = 1'b0; end
            end
         end
         check("c0_rdata", c0_rdata, ref_rdata[0]);
         check("c1_rdata", c1_rdata, ref_rdata[1]);
      end
      prev_strobe = s;
   endtask

   task automatic run_until_quiet(input int maxc);
      int n = 0;
      bit busy;
      do begin
         step();
         n++;
         busy = (pend.size() != 0) || c0_rd || c0_wr || c1_rd || c1_wr || prev_strobe;
      end while (busy && n < maxc);
      check("quiet_timeout", {63'd0, busy}, 0);
   endtask

   task automatic step_until_grant(input int maxc);
      int n = 0;
      int g = grant_log.size();
      while (grant_log.size() == g && n < maxc) begin
         step();
         n++;
      end
      check("grant_timeout", {63'd0, grant_log.size() > g}, 1);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      ref_reset();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      tests = 0; fails = 0; cyc = 0; last_ack_cyc = 0;
      rand_delay = 1'b0;
      auto_drop  = 1'b1;
      for (int i = 0; i < 65536; i++) begin
         mem[i]     = DW'(i * 7 + 3);
         ref_mem[i] = DW'(i * 7 + 3);
      end
      mem[16'h0010] = 16'hBEEF; ref_mem[16'h0010] = 16'hBEEF;
      issue(1'b0, 1'b0, 1'b0, '0, '0);
      issue(1'b1, 1'b0, 1'b0, '0, '0);
      rst = 1'b1;
      ref_reset();
      @(negedge clk);
      check_reset_outputs("reset");
      @(negedge clk);
      rst = 1'b0;

      // Single read with the fixed five-edge memory: ack six cycles after the strobe rises.
      issue(1'b0, 1'b1, 1'b0, 16'h0010, 16'h0);
      step_until_grant(10);
      run_until_quiet(40);
      check("read_latency", 64'(last_ack_cyc - grant_cyc[grant_cyc.size()-1]), 6);
      check("read_beef", c0_rdata, 16'hBEEF);

      // Write then read back on client 1.
      issue(1'b1, 1'b0, 1'b1, 16'h0200, 16'h1234);
      run_until_quiet(40);
      issue(1'b1, 1'b1, 1'b0, 16'h0200, 16'h0);
      run_until_quiet(40);
      check("c1_readback", c1_rdata, 16'h1234);

      // Simultaneous requests straight out of reset: client 0 first.
      do_reset();
      grant_log.delete();
      issue(1'b0, 1'b1, 1'b0, 16'h0001, 16'h0);
      issue(1'b1, 1'b1, 1'b0, 16'h0002, 16'h0);
      run_until_quiet(60);
      check("both_first", grant_log.size() >= 1 ? 64'(grant_log[0]) : 64'hFF, 0);
      check("both_second", grant_log.size() >= 2 ? 64'(grant_log[1]) : 64'hFF, 1);

      // Both held continuously: grants alternate and re-grant comes 8 cycles apart.
      auto_drop = 1'b0;
      grant_log.delete();
      grant_cyc.delete();
      issue(1'b0, 1'b1, 1'b0, 16'h0003, 16'h0);
      issue(1'b1, 1'b1, 1'b0, 16'h0004, 16'h0);
      for (int k = 0; k < 60 && grant_log.size() < 4; k++) step();
      issue(1'b0, 1'b0, 1'b0, 16'h0003, 16'h0);
      issue(1'b1, 1'b0, 1'b0, 16'h0004, 16'h0);
      run_until_quiet(40);
      auto_drop = 1'b1;
      check("alt_count", 64'(grant_log.size()), 4);
      for (int k = 0; k < 4 && k < grant_log.size(); k++)
         check("alt_order", 64'(grant_log[k]), 64'(k % 2));
      if (grant_cyc.size() >= 2)
         check("grant_spacing", 64'(grant_cyc[1] - grant_cyc[0]), 8);

      // rd and wr together is a write.
      issue(1'b0, 1'b1, 1'b1, 16'h0033, 16'hA5A5);
      run_until_quiet(40);
      issue(1'b0, 1'b1, 1'b0, 16'h0033, 16'h0);
      run_until_quiet(40);
      check("rdwr_is_write", c0_rdata, 16'hA5A5);

      // Reset in the middle of a read: outputs clear at once, no ack follows.
      issue(1'b0, 1'b1, 1'b0, 16'h0010, 16'h0);
      step_until_grant(10);
      step();
      step();
      rst = 1'b1;
      #1;
      check_reset_outputs("mid_reset");
      issue(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
      ref_reset();
      @(negedge clk);
      check("mid_reset_no_ack", {62'd0, c0_ack, c1_ack}, 0);
      rst = 1'b0;
      issue(1'b1, 1'b1, 1'b0, 16'h0200, 16'h0);
      run_until_quiet(40);
      check("post_reset_read", c1_rdata, 16'h1234);

      // Client inputs churn while busy; the latched address/data must be used.
      issue(1'b0, 1'b0, 1'b1, 16'h0044, 16'h5A5A);
      step_until_grant(10);
      for (int k = 0; k < 4; k++) begin
         c0_addr  = AW'($urandom);
         c0_wdata = DW'($urandom);
         step();
      end
      run_until_quiet(40);
      issue(1'b1, 1'b1, 1'b0, 16'h0044, 16'h0);
      run_until_quiet(40);
      check("churn_written", c1_rdata, 16'h5A5A);

      // Random traffic with variable memory latency.
      rand_delay = 1'b1;
      for (int it = 0; it < 300; it++) begin
         for (int c = 0; c < 2; c++) begin
            bit idle_c;
            idle_c = (c == 0) ? !(c0_rd || c0_wr) : !(c1_rd || c1_wr);
            if (idle_c && $urandom_range(0, 3) == 0) begin
               int unsigned kind;
               kind = $urandom_range(0, 2);
               issue(c[0], kind != 1, kind != 0,
                     16'h0200 + AW'($urandom_range(0, 3)), DW'($urandom));
            end
         end
         step();
      end
      run_until_quiet(100);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
